// File: rtl/ram_bist_if.sv
// Single RAM port as driven by the BIST engine. Read data is registered and is valid
// the cycle after a read issues.
interface ram_bist_if #(
  parameter int DW = 16,
  parameter int AW = 10
);
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_din,
    input  mem_dout
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_din,
    output mem_dout
  );
endinterface

// File: rtl/ram_bist.sv
// March C- built-in self test for one synchronous RAM port. Reports pass/fail, plus
// the address and march element of the first mismatch.
module ram_bist #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  ram_bist_if.master    ram,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [AW-1:0] ADDR_FIRST = '0;
  localparam logic [AW-1:0] ADDR_LAST  = '1;
  localparam logic [DW-1:0] D0         = '0;
  localparam logic [DW-1:0] D1         = '1;
  localparam logic [2:0]    ELEM_LAST  = 3'd5;

  state_t        state, state_nxt;
  logic [2:0]    elem, elem_nxt;
  logic [AW-1:0] addr, addr_nxt;
  // In r/w elements phase 0 is the read slot and phase 1 the write slot of one address.
  logic          phase, phase_nxt;

  logic          rd_pend;
  logic [DW-1:0] rd_exp;
  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_elem;

  logic          launch;
  logic          mismatch;
  logic          run;
  logic          elem_down, has_read, has_write;
  logic          op_read, op_write, last_slot, sweep_end;
  logic [DW-1:0] rd_pat, wr_pat;

  // Decode of the current march element and slot.
  always_comb begin
    elem_down = (elem == 3'd3) || (elem == 3'd4);
    has_read  = (elem != 3'd0);
    has_write = (elem != ELEM_LAST);
    op_read   = has_read && !phase;
    op_write  = has_write && (!has_read || phase);
    last_slot = !(has_read && has_write) || phase;
    sweep_end = elem_down ? (addr == ADDR_FIRST) : (addr == ADDR_LAST);
    rd_pat    = ((elem == 3'd2) || (elem == 3'd4)) ? D1 : D0;
    wr_pat    = ((elem == 3'd1) || (elem == 3'd3)) ? D1 : D0;
  end

  assign run      = (state == RUN);
  assign launch   = start && ((state == IDLE) || (state == DONE));
  assign mismatch = rd_pend && (ram.mem_dout != rd_exp);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      elem  <= 3'd0;
      addr  <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_nxt;
      elem  <= elem_nxt;
      addr  <= addr_nxt;
      phase <= phase_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can leave a
  // variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    elem_nxt  = elem;
    addr_nxt  = addr;
    phase_nxt = phase;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          elem_nxt  = 3'd0;
          addr_nxt  = ADDR_FIRST;
          phase_nxt = 1'b0;
        end
      end
      RUN: begin
        if (mismatch) begin
          state_nxt = DONE;
        end else if (!last_slot) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (!sweep_end) begin
            addr_nxt = elem_down ? addr - AW'(1) : addr + AW'(1);
          end else if (elem == ELEM_LAST) begin
            state_nxt = FLUSH;
          end else begin
            // Next element starts at the top when it sweeps down (E3, E4).
            elem_nxt = elem + 3'd1;
            addr_nxt = ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_LAST : ADDR_FIRST;
          end
        end
      end
      FLUSH: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read pipeline: expected pattern and origin travel one cycle behind the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_exp  <= '0;
      rd_addr <= '0;
      rd_elem <= 3'd0;
    end else begin
      rd_pend <= run && op_read && !mismatch;
      rd_exp  <= rd_pat;
      rd_addr <= addr;
      rd_elem <= elem;
    end
  end

  // Only the first mismatch is recorded: the FSM leaves RUN/FLUSH right after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 3'd0;
    end else if (launch) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 3'd0;
    end else if (mismatch) begin
      fail      <= 1'b1;
      fail_addr <= rd_addr;
      fail_elem <= rd_elem;
    end
  end

  assign busy         = run || (state == FLUSH);
  assign done         = (state == DONE);
  assign ram.mem_en   = run;
  assign ram.mem_we   = run && op_write;
  assign ram.mem_addr = run ? addr : '0;
  assign ram.mem_din  = (run && op_write) ? wr_pat : '0;

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist (AW=2, DW=8): fault-free RAM model with injectable read faults,
// table-driven and random fault runs checked against a march-level reference model.
module tb_ram_bist;
  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int N     = 1 << AW;
  localparam int LIMIT = 10 * N + 10;

  typedef enum int {F_NONE, F_STUCK, F_DOWN, F_FLIP} fault_t;

  typedef struct {
    fault_t        mode;
    int            f_addr;
    int            f_elem;
    logic [DW-1:0] mask;
    bit            exp_fail;
    int            exp_addr;
    int            exp_elem;
    int            exp_done;
  } vec_t;

  typedef struct packed {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } op_t;

  typedef struct {
    bit down;
    bit rd;
    bit wr;
    bit wval;
  } elem_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;

  ram_bist_if #(.DW(DW), .AW(AW)) bus ();

  ram_bist #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ram       (bus),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM model with registered read data, plus fault injection on the read path.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] ram_q;
  logic [AW-1:0] addr_d;
  int            run_cyc = 0;
  bit            arm = 1'b0;
  fault_t        fault_mode = F_NONE;
  int            f_addr = 0;
  int            f_cyc = -1;
  logic [DW-1:0] f_mask = '0;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
      else            ram_q <= mem[bus.mem_addr];
    end
    addr_d  <= bus.mem_addr;
    run_cyc <= arm ? 1 : run_cyc + 1;
  end

  always_comb begin
    bus.mem_dout = ram_q;
    case (fault_mode)
      F_STUCK: if (int'(addr_d) == f_addr) bus.mem_dout = ram_q | f_mask;
      F_DOWN:  if (int'(addr_d) == f_addr && run_cyc >= 5 * N + 2 && run_cyc <= 9 * N + 1)
                 bus.mem_dout = ram_q ^ f_mask;
      F_FLIP:  if (run_cyc == f_cyc) bus.mem_dout = ram_q ^ f_mask;
      default: ;
    endcase
  end

  // Reference model: March C- element list and the RAM operation stream it implies.
  elem_t march [6];
  op_t   ops [$];

  task automatic build_model();
    int a;
    march[0] = '{down: 0, rd: 0, wr: 1, wval: 0};
    march[1] = '{down: 0, rd: 1, wr: 1, wval: 1};
    march[2] = '{down: 0, rd: 1, wr: 1, wval: 0};
    march[3] = '{down: 1, rd: 1, wr: 1, wval: 1};
    march[4] = '{down: 1, rd: 1, wr: 1, wval: 0};
    march[5] = '{down: 0, rd: 1, wr: 0, wval: 0};
    ops.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = march[e].down ? N - 1 - i : i;
        if (march[e].rd) ops.push_back('{en: 1'b1, we: 1'b0, addr: AW'(a), din: '0});
        if (march[e].wr) ops.push_back('{en: 1'b1, we: 1'b1, addr: AW'(a), din: {DW{march[e].wval}}});
      end
    end
  endtask

  // Cycle (1 = first RUN cycle) in which the read of address a in element e issues.
  function automatic int read_cycle(int e, int a);
    int c, idx;
    c = 1;
    for (int k = 0; k < e; k++) c += N * (int'(march[k].rd) + int'(march[k].wr));
    idx = march[e].down ? N - 1 - a : a;
    return c + idx * (int'(march[e].rd) + int'(march[e].wr));
  endfunction

  function automatic vec_t mk(fault_t m, int fa, int fe, logic [DW-1:0] mk_mask,
                              bit ef, int ea, int ee, int ed);
    vec_t v;
    v = '{mode: m, f_addr: fa, f_elem: fe, mask: mk_mask,
          exp_fail: ef, exp_addr: ea, exp_elem: ee, exp_done: ed};
    return v;
  endfunction

  function automatic logic [31:0] cur_op();
    return 32'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din});
  endfunction

  int trace_addr [64];
  int trace_we   [64];

  // Entered at a negedge; launches one run and follows it until done (or the bound).
  task automatic run_case(input vec_t v, input bit repulse);
    int       k;
    logic [31:0] exp_op;
    fault_mode = v.mode;
    f_addr     = v.f_addr;
    f_mask     = v.mask;
    f_cyc      = (v.mode == F_FLIP) ? read_cycle(v.f_elem, v.f_addr) + 1 : -1;
    start = 1'b1;
    arm   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    arm   = 1'b0;
    check("cleared_on_start", {done, fail, fail_addr, fail_elem}, '0);
    k = 1;
    while (done !== 1'b1 && k <= LIMIT) begin
      exp_op = (k <= 10 * N) ? 32'(ops[k-1]) : 32'd0;
      check($sformatf("op_c%0d", k), cur_op(), exp_op);
      check("busy_run", busy, 1'b1);
      if (k < 64) begin
        trace_addr[k] = int'(bus.mem_addr);
        trace_we[k]   = int'(bus.mem_we);
      end
      start = repulse && (k == 5 || k == 20);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("done_cycle", k, v.exp_done);
    check("fail", fail, v.exp_fail);
    check("fail_addr", fail_addr, v.exp_addr);
    check("fail_elem", fail_elem, v.exp_elem);
    check("idle_at_done", {busy, cur_op()}, '0);
    repeat (3) @(negedge clk);
    check("done_hold", {done, fail, busy, bus.mem_en}, {1'b1, v.exp_fail, 1'b0, 1'b0});
  endtask

  vec_t vecs [$];
  int   e3_addr [8] = '{3, 3, 2, 2, 1, 1, 0, 0};
  int   e3_we   [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    vec_t v;
    int   re, ra;
    build_model();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {busy, done, fail, fail_addr, fail_elem, cur_op()}, '0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_without_start", {busy, done, bus.mem_en}, '0);

    vecs.push_back(mk(F_NONE,  0, 0, 8'h00, 1'b0, 0, 0, 42));
    vecs.push_back(mk(F_STUCK, 2, 0, 8'h01, 1'b1, 2, 1, 11));
    vecs.push_back(mk(F_DOWN,  1, 0, 8'h01, 1'b1, 1, 3, 27));
    vecs.push_back(mk(F_FLIP,  3, 5, 8'h80, 1'b1, 3, 5, 42));
    vecs.push_back(mk(F_FLIP,  0, 1, 8'h10, 1'b1, 0, 1, 7));
    vecs.push_back(mk(F_FLIP,  0, 4, 8'h04, 1'b1, 0, 4, 37));
    vecs.push_back(mk(F_FLIP,  3, 2, 8'hff, 1'b1, 3, 2, 21));
    vecs.push_back(mk(F_NONE,  0, 0, 8'h00, 1'b0, 0, 0, 42));

    foreach (vecs[i]) begin
      run_case(vecs[i], 1'b0);
      if (i == 0) begin
        for (int j = 0; j < 8; j++) begin
          check("e3_addr", trace_addr[5 * N + 1 + j], e3_addr[j]);
          check("e3_we", trace_we[5 * N + 1 + j], e3_we[j]);
        end
      end
    end

    // Random single-read faults; the model predicts the first failing read.
    for (int i = 0; i < 10; i++) begin
      re = int'($urandom_range(5, 1));
      ra = int'($urandom_range(N - 1, 0));
      v  = mk(F_FLIP, ra, re, DW'($urandom_range(255, 1)), 1'b1, ra, re,
              read_cycle(re, ra) + 2);
      run_case(v, 1'b0);
    end

    // start re-pulsed while busy must not disturb the run.
    run_case(vecs[0], 1'b1);

    // Mid-run abort by reset, then a clean run from IDLE.
    fault_mode = F_NONE;
    start = 1'b1;
    arm   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    arm   = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_active", {busy, bus.mem_en}, 2'b11);
    rst = 1'b1;
    #1;
    check("abort_outputs", {busy, done, fail, fail_addr, fail_elem, cur_op()}, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_stays_idle", {busy, done, bus.mem_en}, '0);
    run_case(vecs[0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
